fpu_add_sub_special_pipe: RTL and testbench
===========================================

Name: fpu_add_sub_special_pipe

Overview:
- Parametrised, pipelined special-operand resolver for FP add/sub.
- Classifies raw operands internally and resolves zero/inf/NaN cases to a final result with the invalid flag; flags everything else for the slow datapath.
- Two-stage elastic valid/ready pipeline sits in front of the arithmetic datapath mux. Accumulates a sticky NV flag for fflags.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width, >=2.
- TAG_W, 5, opaque tag width, typically rd index.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block accepts operands
- sub_op_i  in  1  1 = A-B, 0 = A+B
- rm_i  in  3  rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
- a_i, b_i  in  1+EXP_W+MAN_W  raw operands {sign,exp,man}
- tag_i  in  TAG_W  passthrough tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- fast_sel_o  out  1  1 = fast_res_o is final; 0 = slow path required
- fast_res_o  out  1+EXP_W+MAN_W  resolved result, 0 when fast_sel_o=0
- nv_o  out  1  invalid for this result
- tag_o  out  TAG_W  tag of this result
- flags_clr_i  in  1  clear sticky flag
- sticky_nv_o  out  1  OR of nv_o over delivered results since clear

Behaviour:
- Reset (reset_i=0 at posedge): both stage valids, all outputs and sticky flag go to 0. In-flight operations are dropped. in_ready_o=1 in the first cycle after reset.
- Stage 1 registers the classification, effective sign sbe = b.sign ^ sub_op_i, rm and tag. Stage 2 registers the resolved result.
- Latency: 2 cycles from input handshake to out_valid_o when out_ready_i stays high. Full throughput of 1 operation/cycle.
- Handshake: s2_ready = !out_valid_o | out_ready_i; s1_ready = !s1_valid | s2_ready; in_ready_o = s1_ready. Transfers occur only on valid & ready.
- While out_valid_o & !out_ready_i, all outputs stay stable. No bubble is inserted when both stages advance in the same cycle.
- Classification per operand:
  - zero: exp=0, man=0
  - subnormal: exp=0, man!=0; treated as finite and sent to the slow path
  - inf: exp all-ones, man=0
  - NaN: exp all-ones, man!=0
  - sNaN: NaN with man MSB=0
- Resolution, in priority order:
  1. Either operand NaN: result is canonical qNaN {0, all-ones, 1, 0...}. nv = either operand is sNaN.
  2. Both inf: if a.sign == sbe, result is that inf with nv=0. Otherwise result is canonical qNaN with nv=1.
  3. Only A inf: result is A. Only B inf: result is {sbe, B exp, B man}. nv=0 in both cases.
  4. Both zero: if a.sign == sbe, result is that signed zero. Otherwise result is -0 under RDN and +0 under every other rm, including reserved encodings 101-111.
  5. A zero, B finite nonzero: result is {sbe, B exp, B man}. A finite nonzero, B zero: result is A.
  6. Both finite nonzero: fast_sel=0, fast_res=0, nv=0.
- Overflow is never raised here; exact-infinity results are not an overflow.
- Sticky update on each output handshake: sticky <= (flags_clr_i ? 0 : sticky) | (nv_o & out_ready_i). A clear and a set in the same cycle leave the sticky flag at 1. A clear with no handshake sets it to 0.
- Width rules: all-ones and canonical-NaN constants derive from EXP_W/MAN_W. No hardcoded 8/23.

Optional Feature:
- Macro: FPU_SPECIAL_NAN_PROP_EN.
- Defined: a NaN result propagates the payload of the first NaN operand (A before B), quieted by forcing man MSB=1, with the sign kept. Invalid inf-inf still returns canonical qNaN.
- Undefined: every NaN result is canonical qNaN, as in rule 1.
- nv is identical in both builds.

Test Plan:
- Defaults, out_ready_i=1. A=0x7F800000, B=0x7F800000, sub_op=1 -> 2 cycles later fast_sel=1, res=0x7FC00000, nv=1, sticky_nv_o=1 the next cycle.
- A=0x80000000, B=0x00000000, sub_op=0, rm=010 -> res=0x80000000. Same operands with rm=000 -> res=0x00000000. nv=0 in both.
- A=0x00000000, B=0x3F800000, sub_op=1 -> res=0xBF800000. A=0x3F800000, B=0x40000000 -> fast_sel=0, res=0.
- A=0x7F800001 (sNaN), B=0x3F800000 -> res=0x7FC00000, nv=1. With FPU_SPECIAL_NAN_PROP_EN -> res=0x7FC00001.
- Stream of 4 back-to-back ops with out_ready_i low for cycles 3-5: in_ready_o drops once both stages are full, outputs hold, all 4 tags emerge in order, no loss or duplication.
- Assert reset_i=0 with 2 ops in flight -> out_valid_o=0 the next cycle, sticky cleared. flags_clr_i coincident with an nv=1 handshake -> sticky_nv_o=1.

Source files
------------

// File: rtl/fpu_add_sub_special_pipe_if.sv
// ---------------------------------------------------------------------------
// fpu_add_sub_special_pipe_if
//
// Bundles the operand-side and result-side handshakes of the FP add/sub
// special-operand resolver, together with the sticky-flag controls.
//
//   slave  modport : the resolver itself (consumes operands, produces results)
//   master modport : the environment (produces operands, consumes results)
//
// Signals
//   in_valid_i / in_ready_o    operand handshake
//   sub_op_i                   1 = A-B, 0 = A+B
//   rm_i                       rounding mode (000 RNE .. 100 RMM)
//   a_i, b_i                   raw operands {sign, exp, man}
//   tag_i / tag_o              opaque passthrough tag
//   out_valid_o / out_ready_i  result handshake
//   fast_sel_o                 1 = fast_res_o is final, 0 = slow path needed
//   fast_res_o                 resolved result (0 when fast_sel_o = 0)
//   nv_o                       invalid-operation flag for this result
//   flags_clr_i / sticky_nv_o  sticky NV accumulation and clear
// ---------------------------------------------------------------------------
interface fpu_add_sub_special_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid_i;
  logic             in_ready_o;
  logic             sub_op_i;
  logic [2:0]       rm_i;
  logic [W-1:0]     a_i;
  logic [W-1:0]     b_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             fast_sel_o;
  logic [W-1:0]     fast_res_o;
  logic             nv_o;
  logic [TAG_W-1:0] tag_o;
  logic             flags_clr_i;
  logic             sticky_nv_o;

  modport slave (
    input  in_valid_i, sub_op_i, rm_i, a_i, b_i, tag_i, out_ready_i, flags_clr_i,
    output in_ready_o, out_valid_o, fast_sel_o, fast_res_o, nv_o, tag_o, sticky_nv_o
  );

  modport master (
    output in_valid_i, sub_op_i, rm_i, a_i, b_i, tag_i, out_ready_i, flags_clr_i,
    input  in_ready_o, out_valid_o, fast_sel_o, fast_res_o, nv_o, tag_o, sticky_nv_o
  );
endinterface

// File: rtl/fpu_add_sub_special_pipe.sv
// ---------------------------------------------------------------------------
// fpu_add_sub_special_pipe
//
// Two-stage elastic valid/ready pipeline that classifies raw FP add/sub
// operands and resolves every zero / infinity / NaN combination to a final
// result plus invalid flag. Operand pairs that are both finite and nonzero
// (subnormals included) are marked for the slow arithmetic datapath with
// fast_sel = 0 and a zero result. A sticky NV flag accumulates nv over all
// delivered results until cleared.
//
// Ports
//   clk_i    clock
//   reset_i  synchronous active-low reset
//   bus      fpu_add_sub_special_pipe_if.slave (operands, results, flags)
//
// Parameters
//   EXP_W  exponent width
//   MAN_W  stored mantissa width (>= 2)
//   TAG_W  passthrough tag width
//
// Build option
//   FPU_SPECIAL_NAN_PROP_EN  when defined, NaN results carry the payload of
//                            the first NaN operand (A before B), quieted and
//                            with its own sign; invalid inf-inf still yields
//                            the canonical quiet NaN.
//
// Latency is 2 cycles with full throughput.
// ---------------------------------------------------------------------------
module fpu_add_sub_special_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input logic                      clk_i,
  input logic                      reset_i,
  fpu_add_sub_special_pipe_if.slave bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Class vector layout: {snan, nan, inf, zero}. Subnormals are not tracked
  // separately; anything that is none of these is finite nonzero.
  localparam int C_ZERO = 0;
  localparam int C_INF  = 1;
  localparam int C_NAN  = 2;
  localparam int C_SNAN = 3;

  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             e_zero;
    logic             e_ones;
    logic             m_zero;
    e      = x[W-2:MAN_W];
    m      = x[MAN_W-1:0];
    e_zero = (e == '0);
    e_ones = (e == EXP_ONES);
    m_zero = (m == '0);
    classify[C_ZERO] = e_zero & m_zero;
    classify[C_INF]  = e_ones & m_zero;
    classify[C_NAN]  = e_ones & ~m_zero;
    classify[C_SNAN] = e_ones & ~m_zero & ~m[MAN_W-1];
  endfunction

  // Sign of an exact zero produced by opposite-signed zero operands:
  // negative only when rounding toward minus infinity.
  function automatic logic zero_sum_sign(input logic [2:0] rm);
    zero_sum_sign = (rm == 3'b010);
  endfunction

`ifdef FPU_SPECIAL_NAN_PROP_EN
  function automatic logic [W-1:0] nan_result(
    input logic             a_is_nan,
    input logic [W-1:0]     a,
    input logic             b_sign,
    input logic [MAN_W-1:0] b_man
  );
    if (a_is_nan)
      nan_result = {a[W-1], EXP_ONES, 1'b1, a[MAN_W-2:0]};
    else
      nan_result = {b_sign, EXP_ONES, 1'b1, b_man[MAN_W-2:0]};
  endfunction
`endif

  logic             s1_ready;
  logic             s2_ready;

  logic             vld_p1;
  logic [W-1:0]     a_p1;
  logic [EXP_W-1:0] b_exp_p1;
  logic [MAN_W-1:0] b_man_p1;
  logic             sbe_p1;
  logic [2:0]       rm_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [3:0]       cls_a_p1;
  logic [3:0]       cls_b_p1;
`ifdef FPU_SPECIAL_NAN_PROP_EN
  logic             b_sign_p1;
`endif

  logic             rsv_sel;
  logic [W-1:0]     rsv_res;
  logic             rsv_nv;

  logic             vld_p2;
  logic             fast_sel_p2;
  logic [W-1:0]     res_p2;
  logic             nv_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             sticky_nv;

  assign s2_ready       = ~vld_p2 | bus.out_ready_i;
  assign s1_ready       = ~vld_p1 | s2_ready;
  assign bus.in_ready_o = s1_ready;

  // ---- stage 1: register classification, effective B sign, rm and tag ----
  always_ff @(posedge clk_i) begin
    if (s1_ready & bus.in_valid_i) begin
      a_p1     <= bus.a_i;
      b_exp_p1 <= bus.b_i[W-2:MAN_W];
      b_man_p1 <= bus.b_i[MAN_W-1:0];
      sbe_p1   <= bus.b_i[W-1] ^ bus.sub_op_i;
      rm_p1    <= bus.rm_i;
      tag_p1   <= bus.tag_i;
      cls_a_p1 <= classify(bus.a_i);
      cls_b_p1 <= classify(bus.b_i);
`ifdef FPU_SPECIAL_NAN_PROP_EN
      b_sign_p1 <= bus.b_i[W-1];
`endif
    end
  end

  // Resolution in priority order: NaN, inf/inf, single inf, zero/zero,
  // single zero, otherwise slow path.
  always_comb begin
    logic a_sign;
    logic a_zero, a_inf, a_nan, a_snan;
    logic b_zero, b_inf, b_nan, b_snan;
    a_sign = a_p1[W-1];
    a_zero = cls_a_p1[C_ZERO];
    a_inf  = cls_a_p1[C_INF];
    a_nan  = cls_a_p1[C_NAN];
    a_snan = cls_a_p1[C_SNAN];
    b_zero = cls_b_p1[C_ZERO];
    b_inf  = cls_b_p1[C_INF];
    b_nan  = cls_b_p1[C_NAN];
    b_snan = cls_b_p1[C_SNAN];

    rsv_sel = 1'b1;
    rsv_res = '0;
    rsv_nv  = 1'b0;

    if (a_nan | b_nan) begin
`ifdef FPU_SPECIAL_NAN_PROP_EN
      rsv_res = nan_result(a_nan, a_p1, b_sign_p1, b_man_p1);
`else
      rsv_res = QNAN;
`endif
      rsv_nv  = a_snan | b_snan;
    end else if (a_inf & b_inf) begin
      if (a_sign == sbe_p1) begin
        rsv_res = a_p1;
      end else begin
        rsv_res = QNAN;
        rsv_nv  = 1'b1;
      end
    end else if (a_inf) begin
      rsv_res = a_p1;
    end else if (b_inf) begin
      rsv_res = {sbe_p1, b_exp_p1, b_man_p1};
    end else if (a_zero & b_zero) begin
      if (a_sign == sbe_p1)
        rsv_res = {a_sign, {(W-1){1'b0}}};
      else
        rsv_res = {zero_sum_sign(rm_p1), {(W-1){1'b0}}};
    end else if (a_zero) begin
      rsv_res = {sbe_p1, b_exp_p1, b_man_p1};
    end else if (b_zero) begin
      rsv_res = a_p1;
    end else begin
      rsv_sel = 1'b0;
    end
  end

  // ---- stage 2: register resolved result; control and sticky flag ----
  // Output registers are reset along with control so a reset leaves every
  // output at zero.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      fast_sel_p2 <= 1'b0;
      res_p2      <= '0;
      nv_p2       <= 1'b0;
      tag_p2      <= '0;
      sticky_nv   <= 1'b0;
    end else begin
      if (s1_ready)
        vld_p1 <= bus.in_valid_i;
      if (s2_ready) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          fast_sel_p2 <= rsv_sel;
          res_p2      <= rsv_res;
          nv_p2       <= rsv_nv;
          tag_p2      <= tag_p1;
        end
      end
      // A clear and a delivered nv in the same cycle leave the flag set.
      sticky_nv <= (bus.flags_clr_i ? 1'b0 : sticky_nv) |
                   (vld_p2 & bus.out_ready_i & nv_p2);
    end
  end

  assign bus.out_valid_o = vld_p2;
  assign bus.fast_sel_o  = fast_sel_p2;
  assign bus.fast_res_o  = res_p2;
  assign bus.nv_o        = nv_p2;
  assign bus.tag_o       = tag_p2;
  assign bus.sticky_nv_o = sticky_nv;

endmodule

// File: tb/tb_fpu_add_sub_special_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_sub_special_pipe
//
// Directed, self-checking bench for fpu_add_sub_special_pipe with default
// parameters (binary32). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fpu_add_sub_special_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fpu_add_sub_special_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) bus ();

  fpu_add_sub_special_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [2:0]  rm;
    logic        fs;
    logic [31:0] res;
    logic        nv;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.in_valid_i  = 1'b0;
    bus.sub_op_i    = 1'b0;
    bus.rm_i        = 3'b000;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b1;
    bus.flags_clr_i = 1'b0;
  endtask

  // Issues one operation into an idle pipeline and waits (bounded) for its
  // result; returns at the falling edge where out_valid is first seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [2:0] rm,
                       input logic [4:0] tag,
                       output logic fs, output logic [31:0] res,
                       output logic nv, output logic [4:0] tg,
                       output int lat);
    @(negedge clk);
    bus.a_i        = a;
    bus.b_i        = b;
    bus.sub_op_i   = sub;
    bus.rm_i       = rm;
    bus.tag_i      = tag;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    lat = 1;
    while (!bus.out_valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    fs  = bus.fast_sel_o;
    res = bus.fast_res_o;
    nv  = bus.nv_o;
    tg  = bus.tag_o;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid_o); end
    n_assert++; if (bus.fast_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset fast_sel: got %b expected 0", bus.fast_sel_o); end
    n_assert++; if (bus.fast_res_o !== 32'h0) begin n_fail++; $display("FAIL reset fast_res: got %h expected 00000000", bus.fast_res_o); end
    n_assert++; if (bus.nv_o !== 1'b0) begin n_fail++; $display("FAIL reset nv: got %b expected 0", bus.nv_o); end
    n_assert++; if (bus.tag_o !== 5'h0) begin n_fail++; $display("FAIL reset tag: got %h expected 00", bus.tag_o); end
    n_assert++; if (bus.sticky_nv_o !== 1'b0) begin n_fail++; $display("FAIL reset sticky: got %b expected 0", bus.sticky_nv_o); end
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready_o); end
    n_assert++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL post-reset out_valid: got %b expected 0", bus.out_valid_o); end
  endtask

  task automatic test_special();
    logic        fs, nv;
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    // inf - inf -> invalid
    vecs[0]  = '{32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 1'b1, 32'h7FC00000, 1'b1};
    // inf + inf -> inf
    vecs[1]  = '{32'h7F800000, 32'h7F800000, 1'b0, 3'b000, 1'b1, 32'h7F800000, 1'b0};
    // -0 + +0 under RDN / RNE / reserved / RUP
    vecs[2]  = '{32'h80000000, 32'h00000000, 1'b0, 3'b010, 1'b1, 32'h80000000, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h00000000, 1'b0, 3'b000, 1'b1, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h80000000, 32'h00000000, 1'b0, 3'b111, 1'b1, 32'h00000000, 1'b0};
    vecs[5]  = '{32'h80000000, 32'h00000000, 1'b0, 3'b011, 1'b1, 32'h00000000, 1'b0};
    // -0 - +0 -> -0 (same effective signs)
    vecs[6]  = '{32'h80000000, 32'h00000000, 1'b1, 3'b000, 1'b1, 32'h80000000, 1'b0};
    // 0 - 1.0 -> -1.0
    vecs[7]  = '{32'h00000000, 32'h3F800000, 1'b1, 3'b000, 1'b1, 32'hBF800000, 1'b0};
    // 1.0 + 2.0 -> slow path
    vecs[8]  = '{32'h3F800000, 32'h40000000, 1'b0, 3'b000, 1'b0, 32'h00000000, 1'b0};
    // -inf + 1.0 -> -inf ; 1.0 - +inf -> -inf
    vecs[9]  = '{32'hFF800000, 32'h3F800000, 1'b0, 3'b000, 1'b1, 32'hFF800000, 1'b0};
    vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 3'b000, 1'b1, 32'hFF800000, 1'b0};
    // subnormal + -0 -> subnormal ; subnormal + 1.0 -> slow path
    vecs[11] = '{32'h00000001, 32'h80000000, 1'b0, 3'b000, 1'b1, 32'h00000001, 1'b0};
    vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 3'b000, 1'b0, 32'h00000000, 1'b0};
`ifdef FPU_SPECIAL_NAN_PROP_EN
    vecs[13] = '{32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 1'b1, 32'h7FC00001, 1'b1};
    vecs[14] = '{32'h3F800000, 32'hFFC00005, 1'b0, 3'b000, 1'b1, 32'hFFC00005, 1'b0};
    vecs[15] = '{32'h7FC00000, 32'h7F800001, 1'b0, 3'b000, 1'b1, 32'h7FC00000, 1'b1};
`else
    vecs[13] = '{32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 1'b1, 32'h7FC00000, 1'b1};
    vecs[14] = '{32'h3F800000, 32'hFFC00005, 1'b0, 3'b000, 1'b1, 32'h7FC00000, 1'b0};
    vecs[15] = '{32'h7FC00000, 32'h7F800001, 1'b0, 3'b000, 1'b1, 32'h7FC00000, 1'b1};
`endif
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].rm, 5'(i + 1), fs, res, nv, tg, lat);
      n_assert++; if (lat !== 2) begin n_fail++; $display("FAIL special[%0d] latency: got %0d expected 2", i, lat); end
      n_assert++; if (fs !== vecs[i].fs) begin n_fail++; $display("FAIL special[%0d] fast_sel: got %b expected %b", i, fs, vecs[i].fs); end
      n_assert++; if (res !== vecs[i].res) begin n_fail++; $display("FAIL special[%0d] fast_res: got %h expected %h", i, res, vecs[i].res); end
      n_assert++; if (nv !== vecs[i].nv) begin n_fail++; $display("FAIL special[%0d] nv: got %b expected %b", i, nv, vecs[i].nv); end
      n_assert++; if (tg !== 5'(i + 1)) begin n_fail++; $display("FAIL special[%0d] tag: got %0d expected %0d", i, tg, i + 1); end
    end
  endtask

  task automatic test_sticky();
    logic        fs, nv;
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    @(negedge clk);
    bus.flags_clr_i = 1'b1;
    @(negedge clk);
    bus.flags_clr_i = 1'b0;
    n_assert++; if (bus.sticky_nv_o !== 1'b0) begin n_fail++; $display("FAIL sticky clear: got %b expected 0", bus.sticky_nv_o); end
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 5'd20, fs, res, nv, tg, lat);
    n_assert++; if (nv !== 1'b1) begin n_fail++; $display("FAIL sticky op nv: got %b expected 1", nv); end
    n_assert++; if (bus.sticky_nv_o !== 1'b0) begin n_fail++; $display("FAIL sticky before handshake: got %b expected 0", bus.sticky_nv_o); end
    @(negedge clk);
    n_assert++; if (bus.sticky_nv_o !== 1'b1) begin n_fail++; $display("FAIL sticky set: got %b expected 1", bus.sticky_nv_o); end
    bus.flags_clr_i = 1'b1;
    @(negedge clk);
    bus.flags_clr_i = 1'b0;
    n_assert++; if (bus.sticky_nv_o !== 1'b0) begin n_fail++; $display("FAIL sticky clear idle: got %b expected 0", bus.sticky_nv_o); end
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 5'd21, fs, res, nv, tg, lat);
    bus.flags_clr_i = 1'b1;
    @(negedge clk);
    bus.flags_clr_i = 1'b0;
    n_assert++; if (bus.sticky_nv_o !== 1'b1) begin n_fail++; $display("FAIL sticky clear+set: got %b expected 1", bus.sticky_nv_o); end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got  = 0;
    bit          held = 1'b0;
    bit          saw_stall = 1'b0;
    logic [31:0] h_res = '0;
    logic [4:0]  h_tag = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (held) begin
        n_assert++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b hold valid c%0d: got %b expected 1", c, bus.out_valid_o); end
        n_assert++; if (bus.tag_o !== h_tag) begin n_fail++; $display("FAIL b2b hold tag c%0d: got %0d expected %0d", c, bus.tag_o, h_tag); end
        n_assert++; if (bus.fast_res_o !== h_res) begin n_fail++; $display("FAIL b2b hold res c%0d: got %h expected %h", c, bus.fast_res_o, h_res); end
      end
      bus.out_ready_i = !(c >= 3 && c <= 5);
      if (sent < 4) begin
        bus.a_i        = 32'h00000000;
        bus.b_i        = 32'h3F800000 + 32'(sent + 1);
        bus.sub_op_i   = 1'b0;
        bus.rm_i       = 3'b000;
        bus.tag_i      = 5'(sent + 1);
        bus.in_valid_i = 1'b1;
      end else begin
        bus.in_valid_i = 1'b0;
      end
      #1;
      if (sent < 4 && !bus.in_ready_o) saw_stall = 1'b1;
      if (bus.in_valid_i && bus.in_ready_o) sent++;
      if (bus.out_valid_o && bus.out_ready_i) begin
        got++;
        n_assert++; if (bus.tag_o !== 5'(got)) begin n_fail++; $display("FAIL b2b tag #%0d: got %0d expected %0d", got, bus.tag_o, got); end
        n_assert++; if (bus.fast_res_o !== 32'h3F800000 + 32'(got)) begin n_fail++; $display("FAIL b2b res #%0d: got %h expected %h", got, bus.fast_res_o, 32'h3F800000 + 32'(got)); end
        n_assert++; if (bus.fast_sel_o !== 1'b1) begin n_fail++; $display("FAIL b2b fast_sel #%0d: got %b expected 1", got, bus.fast_sel_o); end
      end
      held  = bus.out_valid_o && !bus.out_ready_i;
      h_res = bus.fast_res_o;
      h_tag = bus.tag_o;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    n_assert++; if (got !== 4) begin n_fail++; $display("FAIL b2b result count: got %0d expected 4", got); end
    n_assert++; if (sent !== 4) begin n_fail++; $display("FAIL b2b accept count: got %0d expected 4", sent); end
    n_assert++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready stall: got %b expected 1", saw_stall); end
  endtask

  task automatic test_reset_inflight();
    logic        fs, nv;
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 5'd30, fs, res, nv, tg, lat);
    @(negedge clk);
    n_assert++; if (bus.sticky_nv_o !== 1'b1) begin n_fail++; $display("FAIL inflight pre sticky: got %b expected 1", bus.sticky_nv_o); end
    bus.out_ready_i = 1'b0;
    bus.a_i = 32'h7F800000; bus.b_i = 32'h7F800000; bus.sub_op_i = 1'b1;
    bus.tag_i = 5'd7; bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.tag_i = 5'd8;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    n_assert++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL inflight valid: got %b expected 1", bus.out_valid_o); end
    rst_n = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL inflight reset valid: got %b expected 0", bus.out_valid_o); end
    n_assert++; if (bus.sticky_nv_o !== 1'b0) begin n_fail++; $display("FAIL inflight reset sticky: got %b expected 0", bus.sticky_nv_o); end
    n_assert++; if (bus.tag_o !== 5'd0) begin n_fail++; $display("FAIL inflight reset tag: got %0d expected 0", bus.tag_o); end
    n_assert++; if (bus.nv_o !== 1'b0) begin n_fail++; $display("FAIL inflight reset nv: got %b expected 0", bus.nv_o); end
    n_assert++; if (bus.in_ready_o !== 1'b1) begin n_fail++; $display("FAIL inflight reset in_ready: got %b expected 1", bus.in_ready_o); end
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_assert++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL inflight dropped c%0d: got %b expected 0", c, bus.out_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_special();
    test_sticky();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
